i2c_dual_ram: RTL

I2C_DUAL_RAM -- requirements
Module: i2c_dual_ram

---
 rtl/i2c_dual_ram.sv | 123 ++++++++++++
 1 files changed

// File: rtl/i2c_dual_ram.sv
// Two independent single-write/registered-read RAM banks (local, remote), each with a
// self-sequencing clear engine that also auto-initialises the bank after reset.
module i2c_dual_ram #(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        ADDR_W    = 5,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = DATA_W'(8'h20)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] LocalRAM_RADD,
  output logic [DATA_W-1:0] LocalRAM_DOUT,
  input  logic [ADDR_W-1:0] LocalRAM_WADD,
  input  logic [DATA_W-1:0] LocalRAM_DIN,
  input  logic              LocalRAM_W,
  input  logic              LocalRAM_Clear,
  output logic              LocalRAM_Busy,
  output logic              LocalRAM_Done,
  input  logic [ADDR_W-1:0] RemoteRAM_RADD,
  output logic [DATA_W-1:0] RemoteRAM_DOUT,
  input  logic [ADDR_W-1:0] RemoteRAM_WADD,
  input  logic [DATA_W-1:0] RemoteRAM_DIN,
  input  logic              RemoteRAM_W,
  input  logic              RemoteRAM_Clear,
  output logic              RemoteRAM_Busy,
  output logic              RemoteRAM_Done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StIdle, StClear} state_e;

  // Index 0 is the local bank, index 1 the remote bank.
  logic [ADDR_W-1:0] radd [2];
  logic [ADDR_W-1:0] wadd [2];
  logic [DATA_W-1:0] din  [2];
  logic [DATA_W-1:0] dout [2];
  logic [1:0]        we;
  logic [1:0]        clr;
  logic [1:0]        busy;
  logic [1:0]        done;

  assign radd[0] = LocalRAM_RADD;
  assign wadd[0] = LocalRAM_WADD;
  assign din[0]  = LocalRAM_DIN;
  assign we[0]   = LocalRAM_W;
  assign clr[0]  = LocalRAM_Clear;
  assign radd[1] = RemoteRAM_RADD;
  assign wadd[1] = RemoteRAM_WADD;
  assign din[1]  = RemoteRAM_DIN;
  assign we[1]   = RemoteRAM_W;
  assign clr[1]  = RemoteRAM_Clear;

  assign LocalRAM_DOUT  = dout[0];
  assign LocalRAM_Busy  = busy[0];
  assign LocalRAM_Done  = done[0];
  assign RemoteRAM_DOUT = dout[1];
  assign RemoteRAM_Busy = busy[1];
  assign RemoteRAM_Done = done[1];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              done_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // The clear engine owns the write port while active; reset blocks all writes.
    always_comb begin
      wr_en   = 1'b0;
      wr_addr = wadd[b];
      wr_data = din[b];
      if (state_q == StClear) begin
        wr_en   = rst_n;
        wr_addr = cnt_q;
        wr_data = CLEAR_VAL;
      end else begin
        wr_en   = rst_n && we[b];
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StClear;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        dout_q  <= CLEAR_VAL;
      end else begin
        dout_q <= mem[radd[b]];
        done_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (clr[b]) begin
              state_q <= StClear;
              cnt_q   <= '0;
            end
          end
          StClear: begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (&cnt_q) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign busy[b] = (state_q == StClear);
    assign done[b] = done_q;
    assign dout[b] = dout_q;
  end

endmodule
